// File: rtl/deserializer.sv
// deserializer: collects serial bits into a DATA_W-bit word and hands it off
// with a ready/ack handshake. Define DESER_PARITY_EN to add a trailing
// even-parity bit per word; a word with bad parity is dropped and flagged on
// parity_err.
module deserializer #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_in,
   input  logic              write_in,
   input  logic              ack_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_ready,
   output logic              status_out,
   output logic              parity_err
);
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
`ifdef DESER_PARITY_EN
   typedef enum logic [1:0] {RECV, PAR, READY} state_t;
`else
   typedef enum logic {RECV, READY} state_t;
`endif
   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [DATA_W-1:0] sh, sh_n, dout_n;
   logic              rdy_n, perr_n;
   assign status_out = (state != READY);
   // register all state; reset overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RECV;
         cnt        <= '0;
         sh         <= '0;
         data_out   <= '0;
         data_ready <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         sh         <= sh_n;
         data_out   <= dout_n;
         data_ready <= rdy_n;
         parity_err <= perr_n;
      end
   end
   // next-state: shift bits in RECV, check parity in PAR, hold word until ack in READY
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sh_n    = sh;
      dout_n  = data_out;
      rdy_n   = data_ready;
      perr_n  = 1'b0;
      case (state)
         RECV: begin
            if (write_in) begin
               sh_n  = {sh[DATA_W-2:0], data_in};
               cnt_n = cnt + 1'b1;
               if (cnt == LAST) begin
                  cnt_n = '0;
`ifdef DESER_PARITY_EN
                  state_n = PAR;
`else
                  state_n = READY;
                  dout_n  = sh_n;
                  rdy_n   = 1'b1;
`endif
               end
            end
         end
`ifdef DESER_PARITY_EN
         PAR: begin
            if (write_in) begin
               if (^sh ^ data_in) begin
                  perr_n  = 1'b1;
                  state_n = RECV;
               end else begin
                  state_n = READY;
                  dout_n  = sh;
                  rdy_n   = 1'b1;
               end
            end
         end
`endif
         READY: begin
            if (ack_in) begin
               state_n = RECV;
               rdy_n   = 1'b0;
            end
         end
         default: state_n = RECV;
      endcase
   end
`ifndef DESER_PARITY_EN
   logic unused_par;
   assign unused_par = ^sh_n;
`endif
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed checks of the deserializer handshake, stalls, resets and optional parity (DESER_PARITY_EN)
module tb_deserializer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_in = 1'b0;
   logic       write_in = 1'b0;
   logic       ack_in = 1'b0;
   logic [7:0] data_out;
   logic       data_ready;
   logic       status_out;
   logic       parity_err;
   int         total = 0;
   int         bad = 0;

   deserializer #(.DATA_W(8)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .write_in(write_in), .ack_in(ack_in),
      .data_out(data_out), .data_ready(data_ready), .status_out(status_out), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   // drives one word MSB first (plus parity bit when compiled in), gap idle cycles after each bit;
   // returns whether data_ready was seen before the final bit was sampled
   task automatic send_word(input logic [7:0] w, input int gap, input logic flip_par, output logic early);
      early = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         early |= data_ready;
         write_in = 1'b1;
         data_in  = w[i];
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            write_in = 1'b0;
         end
      end
`ifdef DESER_PARITY_EN
      @(negedge clk);
      early |= data_ready;
      write_in = 1'b1;
      data_in  = (^w) ^ flip_par;
`else
      if (flip_par) early = early;
`endif
      @(negedge clk);
      write_in = 1'b0;
      data_in  = 1'b0;
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack_in = 1'b1;
      @(negedge clk);
      ack_in = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      total++;
      if (data_out !== 8'h00) begin bad++; $display("FAIL reset data_out got=%h want=00", data_out); end
      total++;
      if (data_ready !== 1'b0) begin bad++; $display("FAIL reset data_ready got=%b want=0", data_ready); end
      total++;
      if (status_out !== 1'b1) begin bad++; $display("FAIL reset status_out got=%b want=1", status_out); end
      total++;
      if (parity_err !== 1'b0) begin bad++; $display("FAIL reset parity_err got=%b want=0", parity_err); end
   endtask

   task automatic test_basic();
      logic early;
      send_word(8'hA5, 0, 1'b0, early);
      total++;
      if (early !== 1'b0) begin bad++; $display("FAIL basic early_ready got=%b want=0", early); end
      total++;
      if (data_out !== 8'hA5) begin bad++; $display("FAIL basic data_out got=%h want=a5", data_out); end
      total++;
      if (data_ready !== 1'b1) begin bad++; $display("FAIL basic data_ready got=%b want=1", data_ready); end
      total++;
      if (status_out !== 1'b0) begin bad++; $display("FAIL basic status_out got=%b want=0", status_out); end
      do_ack();
      total++;
      if (data_ready !== 1'b0) begin bad++; $display("FAIL basic_ack data_ready got=%b want=0", data_ready); end
      total++;
      if (status_out !== 1'b1) begin bad++; $display("FAIL basic_ack status_out got=%b want=1", status_out); end
      total++;
      if (data_out !== 8'hA5) begin bad++; $display("FAIL basic_ack data_out got=%h want=a5", data_out); end
   endtask

   task automatic test_stall_gaps();
      logic early;
      send_word(8'h3C, 2, 1'b0, early);
      total++;
      if (data_out !== 8'h3C || data_ready !== 1'b1) begin bad++; $display("FAIL gaps word got=%h/%b want=3c/1", data_out, data_ready); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         write_in = 1'b1;
         data_in  = 1'b1;
      end
      @(negedge clk);
      write_in = 1'b0;
      total++;
      if (data_out !== 8'h3C || status_out !== 1'b0) begin bad++; $display("FAIL stall hold got=%h/%b want=3c/0", data_out, status_out); end
      do_ack();
      send_word(8'h81, 0, 1'b0, early);
      total++;
      if (data_out !== 8'h81 || data_ready !== 1'b1 || early !== 1'b0) begin bad++; $display("FAIL after_stall got=%h/%b/%b want=81/1/0", data_out, data_ready, early); end
   endtask

   task automatic test_simultaneous();
      logic early;
      @(negedge clk);
      ack_in   = 1'b1;
      write_in = 1'b1;
      data_in  = 1'b0;
      @(negedge clk);
      ack_in   = 1'b0;
      write_in = 1'b0;
      total++;
      if (data_ready !== 1'b0 || status_out !== 1'b1) begin bad++; $display("FAIL simul ack got=%b/%b want=0/1", data_ready, status_out); end
      send_word(8'hFF, 0, 1'b0, early);
      total++;
      if (data_out !== 8'hFF || data_ready !== 1'b1 || early !== 1'b0) begin bad++; $display("FAIL simul word got=%h/%b/%b want=ff/1/0", data_out, data_ready, early); end
      do_ack();
   endtask

   task automatic test_reset_mid();
      logic early;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         write_in = 1'b1;
         data_in  = 1'b1;
      end
      @(negedge clk);
      write_in = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (data_ready !== 1'b0 || status_out !== 1'b1 || data_out !== 8'h00) begin bad++; $display("FAIL rst_mid state got=%h/%b/%b want=00/0/1", data_out, data_ready, status_out); end
      send_word(8'h0F, 0, 1'b0, early);
      total++;
      if (early !== 1'b0) begin bad++; $display("FAIL rst_mid early_ready got=%b want=0", early); end
      total++;
      if (data_out !== 8'h0F || data_ready !== 1'b1) begin bad++; $display("FAIL rst_mid word got=%h/%b want=0f/1", data_out, data_ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (data_out !== 8'h00 || data_ready !== 1'b0 || status_out !== 1'b1) begin bad++; $display("FAIL rst_ready got=%h/%b/%b want=00/0/1", data_out, data_ready, status_out); end
   endtask

   task automatic test_parity();
      logic early;
`ifdef DESER_PARITY_EN
      send_word(8'hA5, 0, 1'b0, early);
      total++;
      if (data_out !== 8'hA5 || data_ready !== 1'b1 || parity_err !== 1'b0) begin bad++; $display("FAIL par_good got=%h/%b/%b want=a5/1/0", data_out, data_ready, parity_err); end
      do_ack();
      send_word(8'h5A, 0, 1'b1, early);
      total++;
      if (parity_err !== 1'b1 || data_ready !== 1'b0 || status_out !== 1'b1) begin bad++; $display("FAIL par_bad got=%b/%b/%b want=1/0/1", parity_err, data_ready, status_out); end
      total++;
      if (data_out !== 8'hA5) begin bad++; $display("FAIL par_bad data_out got=%h want=a5", data_out); end
      @(negedge clk);
      total++;
      if (parity_err !== 1'b0 || data_ready !== 1'b0) begin bad++; $display("FAIL par_pulse got=%b/%b want=0/0", parity_err, data_ready); end
`else
      send_word(8'h01, 0, 1'b0, early);
      total++;
      if (parity_err !== 1'b0 || data_out !== 8'h01 || data_ready !== 1'b1) begin bad++; $display("FAIL no_par got=%b/%h/%b want=0/01/1", parity_err, data_out, data_ready); end
      do_ack();
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall_gaps();
      test_simultaneous();
      test_reset_mid();
      test_parity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel input stage that collects single bits presented with a write strobe into a `DATA_W`-bit word. It presents the completed word to the downstream word queue through a ready/acknowledge handshake and stalls the serial source through `status_out` while a word is unacknowledged. It runs on the system clock. The queue consumer sits on the same clock domain as the handshake.

## Interface
- `DATA_W`, default 8: word width in bits; legal range 2–32.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `data_in`  input  1: serial bit, sampled when `write_in` is high and `status_out` is high.
- `write_in`  input  1: bit strobe, one bit per high cycle.
- `ack_in`  input  1: downstream acknowledge of the presented word.
- `data_out`  output  `DATA_W`: assembled word, registered.
- `data_ready`  output  1: `data_out` valid, held until acknowledged.
- `status_out`  output  1: high when the block accepts serial bits.
- `parity_err`  output  1: one-cycle pulse on a rejected word; constant 0 when parity is not compiled in.

## Operation
- State machine states:
  - RECV: accept bits.
  - PAR: await the parity bit; exists only with the macro.
  - READY: hold the word.
- Reset values, applied at any clock edge with `rst`=1 and overriding everything else:
  - state RECV, bit counter 0, shift register 0.
  - `data_out`=0, `data_ready`=0, `status_out`=1, `parity_err`=0.
- RECV:
  - Each cycle with `write_in`=1 shifts `data_in` into the LSB of the shift register, so the first bit received ends up as the MSB.
  - The bit counter increments on each accepted bit.
  - Cycles with `write_in`=0 leave the state unchanged. Gaps between bits are unlimited.
- On the `DATA_W`-th accepted bit:
  - Without the macro: go to READY. `data_out` loads the full word, `data_ready` goes to 1, `status_out` goes to 0, and the counter clears.
  - With the macro: go to PAR. `status_out` stays 1.
- READY:
  - `write_in` is ignored and the bit is dropped. The source must honour `status_out`.
  - `ack_in`=1 returns the block to RECV at the next edge: `data_ready` goes to 0 and `status_out` goes to 1.
  - `data_out` keeps its value until the next word loads.
- `ack_in` outside READY is ignored.
- `write_in` and `ack_in` high in the same READY cycle: the ack is taken and the bit is dropped.
- Counter width is `$clog2(DATA_W+1)` and it never wraps past `DATA_W`.

## Timing
- Latency from the edge sampling the last data bit (or the parity bit) to `data_ready`=1 and `status_out`=0 is 1 cycle. Both are registered and change on that same edge.
- Latency from the edge sampling `ack_in`=1 to `data_ready`=0 and `status_out`=1 is 1 cycle.
- Minimum word period is `DATA_W`+1 cycles: `DATA_W` bit cycles plus 1 ack cycle. With parity it is `DATA_W`+2.
- `status_out` is combinationally equal to (state != READY), taken from registered state.
- Reset asserted mid-word discards the partial word. Reset asserted in READY drops the held word and clears `data_out`. The first bit is accepted on the first cycle after `rst` deasserts.

## Configuration
- Macro `DESER_PARITY_EN`.
- Defined:
  - After `DATA_W` data bits, one extra bit is accepted in PAR as an even-parity bit.
  - If the XOR of the data bits and the parity bit is 0, go to READY with the word as above.
  - If it is 1, discard the word, pulse `parity_err` for exactly 1 cycle, return to RECV, and leave `data_out` at its old value.
- Undefined: there is no PAR state and `parity_err` is tied to 0.

## Test plan
- Reset check: assert `rst` for 2 cycles -> `data_out`=0x00, `data_ready`=0, `status_out`=1, `parity_err`=0.
- Basic word: send bits 1,0,1,0,0,1,0,1 on consecutive cycles -> 1 cycle after the 8th bit, `data_out`=0xA5, `data_ready`=1, `status_out`=0. Pulse `ack_in` -> next cycle `data_ready`=0, `status_out`=1, `data_out` still 0xA5.
- Stall and gaps: send 0x3C with idle cycles between bits, then hold `write_in`=1 with `data_in`=1 for 4 cycles in READY before the ack -> `data_out`=0x3C is unchanged. The next word 0x81 sent after the ack assembles correctly as 0x81.
- Simultaneous events: in READY, assert `ack_in` and `write_in` together -> the bit is dropped. A following 8-bit stream 0xFF yields `data_out`=0xFF.
- Reset mid-word: send 5 bits, assert `rst` for 1 cycle, then send 0x0F -> `data_out`=0x0F and no spurious `data_ready` before the 8th bit.
- Parity (`DESER_PARITY_EN`): send 0xA5 followed by parity bit 0 -> `data_ready`=1 with 0xA5. Send 0xA5 followed by parity bit 1 -> `parity_err` high for 1 cycle, `data_ready` stays 0, `status_out` stays 1.
